// File: rtl/iomem_timer.sv
// rtl/iomem_timer.sv - memory-mapped prescaled up-counter with compare match and level irq
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_COMPARE  = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  logic        en_q, en_d;
  logic        autoreload_q, autoreload_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] prescale_q, prescale_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        match_q, match_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        ready_q, ready_d;
  logic        done_q, done_d;

  logic        sel;
  logic        wr_en;
  logic [2:0]  reg_idx;
  logic [31:0] rd_val;
  logic [31:0] merged;
  logic        tick;
  logic        hit;
  logic        unused_bits;

  assign sel     = iomem_valid && (iomem_addr[31:5] == BASE_ADDR[31:5]);
  assign reg_idx = iomem_addr[4:2];
  assign wr_en   = ready_q && sel && (iomem_wstrb != 4'b0000);
  assign tick    = en_q && (pcnt_q == prescale_q);
  assign hit     = tick && (count_q == compare_q);

  assign iomem_ready = ready_q && sel;
  assign iomem_rdata = iomem_ready ? rd_val : 32'h0;
  assign irq         = match_q && irq_en_q;
  assign unused_bits = ^{iomem_addr[1:0], merged[31:16]};

  always_comb begin
    rd_val = 32'h0;
    case (reg_idx)
      REG_CTRL:     rd_val = {29'h0, irq_en_q, autoreload_q, en_q};
      REG_PRESCALE: rd_val = {16'h0, prescale_q};
      REG_COUNT:    rd_val = count_q;
      REG_COMPARE:  rd_val = compare_q;
      REG_STATUS:   rd_val = {31'h0, match_q};
      default:      rd_val = 32'h0;
    endcase
  end

  // Byte-merge the write data over the current register value so every
  // register shares the same wstrb handling.
  always_comb begin
    merged = rd_val;
    for (int b = 0; b < 4; b++) begin
      if (iomem_wstrb[b]) merged[8*b +: 8] = iomem_wdata[8*b +: 8];
    end
  end

  always_comb begin
    en_d         = en_q;
    autoreload_d = autoreload_q;
    irq_en_d     = irq_en_q;
    prescale_d   = prescale_q;
    count_d      = count_q;
    compare_d    = compare_q;
    match_d      = match_q;
    pcnt_d       = pcnt_q;
    ready_d      = sel && !ready_q && !done_q;
    done_d       = iomem_valid && (ready_q || done_q);

    if (!en_q || tick) pcnt_d = 16'h0;
    else               pcnt_d = pcnt_q + 16'd1;

    if (hit) begin
      if (autoreload_q) count_d = 32'h0;
      else              en_d    = 1'b0;
    end else if (tick) begin
      count_d = count_q + 32'd1;
    end

    // A new match overrides a coincident write-1-to-clear.
    if (wr_en && reg_idx == REG_STATUS && iomem_wstrb[0] && iomem_wdata[0]) match_d = 1'b0;
    if (hit) match_d = 1'b1;

    // Software writes land last so they win over the timer's own updates.
    if (wr_en) begin
      case (reg_idx)
        REG_CTRL: begin
          en_d         = merged[0];
          autoreload_d = merged[1];
          irq_en_d     = merged[2];
        end
        REG_PRESCALE: begin
          prescale_d = merged[15:0];
          pcnt_d     = 16'h0;
        end
        REG_COUNT:   count_d   = merged;
        REG_COMPARE: compare_d = merged;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      en_q         <= 1'b0;
      autoreload_q <= 1'b0;
      irq_en_q     <= 1'b0;
      prescale_q   <= 16'h0;
      count_q      <= 32'h0;
      compare_q    <= 32'hFFFF_FFFF;
      match_q      <= 1'b0;
      pcnt_q       <= 16'h0;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      en_q         <= en_d;
      autoreload_q <= autoreload_d;
      irq_en_q     <= irq_en_d;
      prescale_q   <= prescale_d;
      count_q      <= count_d;
      compare_q    <= compare_d;
      match_q      <= match_d;
      pcnt_q       <= pcnt_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_iomem_timer.sv
// tb/tb_iomem_timer.sv - randomized bench for iomem_timer against an arithmetic timer model
module tb_iomem_timer;
  localparam logic [31:0] BASE = 32'h0300_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00, A_PRE = BASE + 32'h04, A_CNT = BASE + 32'h08;
  localparam logic [31:0] A_CMP = BASE + 32'h0C, A_STAT = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        resetn;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        irq;

  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;

  logic [31:0] m_s, m_c;
  int          m_p;
  bit          m_ar;
  longint      m_base;

  iomem_timer #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Timer state in cycle c, counting whole prescaled periods since enable at m_base.
  function automatic void model(input longint c, output logic [31:0] cnt, output bit m, output bit en);
    longint n, ticks, d;
    logic [31:0] dd;
    n = c - m_base;
    ticks = n / (m_p + 1);
    dd = m_c - m_s;
    d = {32'd0, dd};
    if (ticks <= d) begin
      cnt = m_s + ticks[31:0]; m = 0; en = 1;
    end else if (m_ar) begin
      n = (ticks - d - 1) % ({32'd0, m_c} + 1);
      cnt = n[31:0]; m = 1; en = 1;
    end else begin
      cnt = m_c; m = 1; en = 0;
    end
  endfunction

  task automatic do_reset();
    iomem_valid = 0; iomem_wstrb = 0; iomem_addr = 0; iomem_wdata = 0;
    resetn = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;
  endtask

  task automatic xfer(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                      output logic [31:0] rdata, output longint rc);
    bit got;
    got = 0; rdata = 0; rc = 0;
    @(posedge clk); #1;
    iomem_valid = 1; iomem_addr = addr; iomem_wdata = wdata; iomem_wstrb = strb;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (iomem_ready) begin got = 1; rdata = iomem_rdata; rc = cyc; end
    end
    if (!got) check_eq("bus_timeout", 0, 1);
    @(posedge clk); #1;
    iomem_valid = 0; iomem_wstrb = 0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, output longint rc);
    logic [31:0] dummy;
    xfer(addr, data, strb, dummy, rc);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data, output longint rc);
    xfer(addr, 32'h0, 4'h0, data, rc);
  endtask

  task automatic start_timer(input int p, input logic [31:0] c, input logic [31:0] s, input bit ar, input bit ie);
    longint rc;
    m_p = p; m_c = c; m_s = s; m_ar = ar;
    wr(A_PRE, p, 4'hF, rc);
    wr(A_CMP, c, 4'hF, rc);
    wr(A_CNT, s, 4'hF, rc);
    wr(A_CTRL, {29'h0, ie, ar, 1'b1}, 4'hF, rc);
    m_base = rc + 1;
  endtask

  initial begin
    logic [31:0] d, ecnt, c32, s32;
    longint rc, rc2, span;
    int readies, p;
    bit em, een, ar, ie;

    do_reset();
    check_eq("rst_ready", iomem_ready, 0);
    check_eq("rst_rdata", iomem_rdata, 0);
    check_eq("rst_irq", irq, 0);
    rd(A_CTRL, d, rc); check_eq("rst_ctrl", d, 0);
    rd(A_PRE, d, rc);  check_eq("rst_prescale", d, 0);
    rd(A_CNT, d, rc);  check_eq("rst_count", d, 0);
    rd(A_CMP, d, rc);  check_eq("rst_compare", d, 32'hFFFF_FFFF);
    rd(A_STAT, d, rc); check_eq("rst_status", d, 0);

    foreach (d[i]) begin end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      iomem_valid = 1; iomem_wstrb = 0;
      iomem_addr = (k == 0) ? BASE + 32'h20 : (k == 1) ? BASE - 32'h4 : 32'h0200_0000;
      readies = 0;
      repeat (6) begin @(negedge clk); if (iomem_ready) readies++; end
      check_eq("out_of_window_ready", readies, 0);
      @(posedge clk); #1 iomem_valid = 0;
    end

    @(posedge clk); #1;
    iomem_valid = 1; iomem_addr = A_CMP; iomem_wstrb = 0;
    readies = 0;
    repeat (6) begin @(negedge clk); if (iomem_ready) readies++; end
    check_eq("held_valid_single_ready", readies, 1);
    @(posedge clk); #1 iomem_valid = 0;

    wr(A_CMP, 32'h1122_3344, 4'hF, rc);
    wr(A_CMP, 32'hAABB_CCDD, 4'b0010, rc);
    rd(A_CMP, d, rc); check_eq("wstrb_compare", d, 32'h1122_CC44);
    wr(A_PRE, 32'hFFFF_FFFF, 4'hF, rc);
    rd(A_PRE, d, rc); check_eq("prescale_width", d, 32'h0000_FFFF);
    wr(A_CTRL, 32'hFFFF_FFF8, 4'hF, rc);
    rd(A_CTRL, d, rc); check_eq("ctrl_upper_bits", d, 0);
    wr(BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, rc);
    rd(BASE + 32'h18, d, rc); check_eq("reserved_read", d, 0);

    // Randomized timer runs: each run checks counter, status, enable and irq at random points.
    for (int it = 0; it < 10; it++) begin
      do_reset();
      p = $urandom_range(0, 3);
      c32 = $urandom_range(0, 6);
      case ($urandom_range(0, 2))
        0: s32 = 0;
        1: s32 = c32 - ((c32 > 3) ? $urandom_range(0, 3) : 0);
        default: begin c32 = $urandom_range(0, 4); s32 = 32'hFFFF_FFFE; end
      endcase
      ar = $urandom_range(0, 1);
      ie = $urandom_range(0, 1);
      start_timer(p, c32, s32, ar, ie);
      span = ({32'd0, c32 - s32} + 3) * (p + 1);
      for (int pr = 0; pr < 4; pr++) begin
        repeat ($urandom_range(0, int'(span))) @(posedge clk);
        rd(A_CNT, d, rc);
        model(rc, ecnt, em, een);
        check_eq("rand_count", d, ecnt);
        rd(A_STAT, d, rc);
        model(rc, ecnt, em, een);
        check_eq("rand_match", d, em);
        rd(A_CTRL, d, rc);
        model(rc, ecnt, em, een);
        check_eq("rand_ctrl", d, {29'h0, ie, ar, een});
        @(negedge clk);
        model(cyc, ecnt, em, een);
        check_eq("rand_irq", irq, em & ie);
      end
    end

    do_reset();
    start_timer(3, 2, 0, 1, 1);
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      model(cyc, ecnt, em, een);
      check_eq("autoreload_irq_trace", irq, em);
    end

    do_reset();
    start_timer(0, 5, 0, 0, 1);
    repeat (10) @(posedge clk);
    rd(A_CTRL, d, rc); check_eq("oneshot_ctrl", d, 32'h4);
    rd(A_CNT, d, rc);  check_eq("oneshot_count", d, 5);
    check_eq("oneshot_irq", irq, 1);
    wr(A_STAT, 32'h1, 4'hF, rc);
    @(negedge clk); check_eq("w1c_irq_drop", irq, 0);

    do_reset();
    start_timer(0, 0, 0, 1, 1);
    repeat (3) @(posedge clk);
    wr(A_STAT, 32'h1, 4'hF, rc);
    @(negedge clk); check_eq("w1c_vs_match", irq, 1);

    do_reset();
    start_timer(0, 32'hFFFF_FFFF, 0, 1, 0);
    repeat (5) @(posedge clk);
    wr(A_CNT, 32'h100, 4'hF, rc);
    rd(A_CNT, d, rc2);
    ecnt = 32'h100 + 32'(rc2 - (rc + 1));
    check_eq("count_write_vs_tick", d, ecnt);

    do_reset();
    start_timer(3, 32'd1000, 0, 1, 0);
    repeat ($urandom_range(0, 7)) @(posedge clk);
    wr(A_PRE, 32'h3, 4'hF, rc);
    rd(A_CNT, d, rc2);
    ecnt = 32'((rc + 1 - m_base) / 4 + (rc2 - (rc + 1)) / 4);
    check_eq("prescale_write_rephase", d, ecnt);

    do_reset();
    @(posedge clk); #1;
    iomem_valid = 1; iomem_addr = A_CTRL; iomem_wdata = 32'h7; iomem_wstrb = 4'hF;
    resetn = 0;
    readies = 0;
    repeat (3) begin @(negedge clk); if (iomem_ready || iomem_rdata != 0 || irq) readies++; end
    check_eq("reset_abort_quiet", readies, 0);
    @(posedge clk); #1 iomem_valid = 0; iomem_wstrb = 0;
    @(posedge clk); #1 resetn = 1;
    rd(A_CTRL, d, rc); check_eq("reset_abort_ctrl", d, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
